remote_comm: RTL
================

Name: remote_comm

Overview:
Host-side counterpart of the command link. Accepts a 16-bit command with a single-cycle strobe and serializes it over UART TX as two frames, high byte first then low byte. Concurrently deserializes the 8-bit response byte arriving on RX and presents it with a ready flag. Used in the host/testbench model and on any controller that drives the command interface.

Parameters:
BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); legal range 16..65535.
TIMEOUT_CYC, 5000000, response wait limit in clocks (only used with RESP_TIMEOUT_EN).

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
snd_cmd  input  1  1-cycle strobe: capture cmd and start transmission
cmd  input  16  command word; sampled only on an accepted snd_cmd
cmd_snt  output  1  set when the low byte's stop bit completes
busy  output  1  high from accept through the end of the low-byte stop bit
TX  output  1  serial out, idle high
RX  input  1  serial in, asynchronous, idle high
resp  output  8  last received response byte
resp_rdy  output  1  response byte valid
clr_resp_rdy  input  1  clears resp_rdy
resp_timeout  output  1  response wait expired (constant 0 when feature absent)

Behaviour:
- Reset is synchronous and active-low. All state updates only on the posedge of clk.
- Reset values: TX=1, cmd_snt=0, busy=0, resp=8'h00, resp_rdy=0, resp_timeout=0. The FSM returns to IDLE.
- Reset asserted mid-frame aborts the frame. TX is high on the first clock edge with rst_n=0.
- TX frame format: start bit 0, data LSB first, stop bit 1. Each bit lasts exactly BAUD_DIV clocks, so one frame is 10*BAUD_DIV clocks.
- TX FSM states: IDLE, TX_HIGH, TX_LOW.
  - IDLE + snd_cmd: latch cmd[15:0], load cmd[15:8] into the shift register, clear cmd_snt, set busy, go to TX_HIGH.
  - The start bit appears on TX the cycle after the strobe.
  - TX_HIGH, end of stop bit: load cmd[7:0], go to TX_LOW. The next start bit begins the following cycle; there is no idle gap between frames.
  - TX_LOW, end of stop bit: set cmd_snt, clear busy, go to IDLE. snd_cmd is accepted on the very next cycle.
- snd_cmd while busy=1 is ignored. Neither the latched command nor the frame in progress is disturbed.
- Latency from snd_cmd to cmd_snt is 20*BAUD_DIV+1 clocks.
- cmd_snt stays high until the next accepted snd_cmd.
- RX path:
  - RX passes through a 2-flop synchronizer, reset to 1.
  - IDLE state: a falling edge on the synchronized RX starts a frame.
  - Sampling points: mid-bit at BAUD_DIV/2 (integer divide) for the start bit, then every BAUD_DIV clocks for 8 data bits and the stop bit.
  - Start bit sampled high: false start; return to idle and leave resp/resp_rdy unchanged.
  - Stop bit sample: load resp and set resp_rdy, regardless of the stop bit's value. Framing errors are not flagged.
- resp_rdy clearing:
  - Cleared by clr_resp_rdy.
  - Also cleared when the next RX start bit is detected.
  - If set and clr_resp_rdy coincide, set wins.
- The TX and RX paths are fully independent and may be active simultaneously.

Optional Feature:
Macro RESP_TIMEOUT_EN.
- Defined:
  - A 32-bit counter starts when cmd_snt rises.
  - It stops and clears when resp_rdy sets or when snd_cmd is accepted.
  - When the count reaches TIMEOUT_CYC, resp_timeout sets.
  - resp_timeout is cleared by the next accepted snd_cmd or by resp_rdy setting.
- Not defined: no counter is built and resp_timeout is tied to 0.

Test Plan (BAUD_DIV=16, TIMEOUT_CYC=1000 unless noted):
1. Reset, then snd_cmd with cmd=16'hA55A -> TX carries frame 8'hA5 then frame 8'h5A, bits sampled at bit centers match. Each frame is 160 clocks. cmd_snt rises 321 clocks after the strobe and busy falls in the same cycle.
2. Second snd_cmd with cmd=16'h1234 during the high-byte frame of an 16'hA55A transfer -> transfer still sends A5, 5A. The cycle after busy falls, snd_cmd with 16'h1234 sends 12, 34 and cmd_snt dips low for that transfer.
3. Serial 8'hC3 driven on RX -> resp=8'hC3 and resp_rdy=1 after the stop-bit sample. clr_resp_rdy pulse -> resp_rdy=0 next cycle and resp holds 8'hC3.
4. 4-clock low glitch on RX -> no resp_rdy and resp unchanged. Next, RX frame 8'h0F sent while TX transmits 16'hFFFF -> both complete correctly.
5. rst_n low for 1 cycle midway through the low-byte frame -> TX=1, busy=0, cmd_snt=0 the next cycle. A new 16'h00FF transfer then completes normally.
6. With RESP_TIMEOUT_EN defined: send a command with no RX response -> resp_timeout=1 exactly 1000 clocks after cmd_snt rises. Repeat with an 8'hA5 response at cycle 500 -> resp_timeout stays 0.

Source files
------------

// File: rtl/remote_comm.sv
// Host command link: 16-bit command sent as two UART frames (high byte first), 8-bit response received.
// Optional response-wait timeout is built only when RESP_TIMEOUT_EN is defined.
module remote_comm #(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    output logic        cmd_snt,
    output logic        busy,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    input  logic        clr_resp_rdy,
    output logic        resp_timeout
);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, TX_HIGH, TX_LOW} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t   tx_state, tx_state_nxt;
    logic [15:0] tx_cnt, tx_cnt_nxt;
    logic [3:0]  tx_bit, tx_bit_nxt;
    logic [8:0]  tx_shift, tx_shift_nxt;    // data bits still to go, stop bit on top
    logic [7:0]  cmd_lo, cmd_lo_nxt;
    logic        tx_nxt, cmd_snt_nxt, busy_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
            cmd_lo   <= '0;
            TX       <= 1'b1;
            cmd_snt  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            cmd_lo   <= cmd_lo_nxt;
            TX       <= tx_nxt;
            cmd_snt  <= cmd_snt_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        cmd_lo_nxt   = cmd_lo;
        tx_nxt       = TX;
        cmd_snt_nxt  = cmd_snt;
        busy_nxt     = busy;
        case (tx_state)
            IDLE: begin
                if (snd_cmd) begin
                    tx_state_nxt = TX_HIGH;
                    cmd_lo_nxt   = cmd[7:0];
                    tx_shift_nxt = {1'b1, cmd[15:8]};
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_nxt       = 1'b0;
                    cmd_snt_nxt  = 1'b0;
                    busy_nxt     = 1'b1;
                end
            end
            TX_HIGH, TX_LOW: begin
                if (tx_cnt != BAUD_LAST) begin
                    tx_cnt_nxt = tx_cnt + 16'd1;
                end else begin
                    tx_cnt_nxt = '0;
                    if (tx_bit != 4'd9) begin
                        tx_nxt       = tx_shift[0];
                        tx_shift_nxt = {1'b1, tx_shift[8:1]};
                        tx_bit_nxt   = tx_bit + 4'd1;
                    end else if (tx_state == TX_HIGH) begin
                        // low byte's start bit follows the high byte's stop bit with no gap
                        tx_state_nxt = TX_LOW;
                        tx_shift_nxt = {1'b1, cmd_lo};
                        tx_bit_nxt   = '0;
                        tx_nxt       = 1'b0;
                    end else begin
                        tx_state_nxt = IDLE;
                        tx_nxt       = 1'b1;
                        cmd_snt_nxt  = 1'b1;
                        busy_nxt     = 1'b0;
                    end
                end
            end
            default: tx_state_nxt = IDLE;
        endcase
    end

    logic [2:0]  rx_sync;                   // [1] synchronized RX, [2] its previous value
    logic        rx_s;
    rx_state_t   rx_state, rx_state_nxt;
    logic [15:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]  rx_bit, rx_bit_nxt;
    logic [7:0]  rx_shift, rx_shift_nxt, resp_nxt;
    logic        resp_rdy_nxt;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sync  <= 3'b111;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            resp     <= '0;
            resp_rdy <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[1:0], RX};
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
            resp     <= resp_nxt;
            resp_rdy <= resp_rdy_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        resp_nxt     = resp;
        resp_rdy_nxt = resp_rdy & ~clr_resp_rdy;
        case (rx_state)
            RX_IDLE: begin
                if (rx_sync[2] && !rx_s) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt != HALF_LAST) begin
                    rx_cnt_nxt = rx_cnt + 16'd1;
                end else begin
                    rx_cnt_nxt = '0;
                    rx_bit_nxt = '0;
                    // a start bit that is high again at mid-bit was a glitch
                    if (rx_s) begin
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_state_nxt = RX_DATA;
                        resp_rdy_nxt = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt != BAUD_LAST) begin
                    rx_cnt_nxt = rx_cnt + 16'd1;
                end else begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_s, rx_shift[7:1]};
                    rx_bit_nxt   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt != BAUD_LAST) begin
                    rx_cnt_nxt = rx_cnt + 16'd1;
                end else begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = RX_IDLE;
                    resp_nxt     = rx_shift;
                    resp_rdy_nxt = 1'b1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

`ifdef RESP_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    logic        cmd_accept, tx_done, resp_set;
    logic        to_run;
    logic [31:0] to_cnt;

    assign cmd_accept = (tx_state == IDLE) && snd_cmd;
    assign tx_done    = (tx_state == TX_LOW) && (tx_cnt == BAUD_LAST) && (tx_bit == 4'd9);
    assign resp_set   = (rx_state == RX_STOP) && (rx_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_run       <= 1'b0;
            to_cnt       <= '0;
            resp_timeout <= 1'b0;
        end else if (cmd_accept || resp_set) begin
            to_run       <= 1'b0;
            to_cnt       <= '0;
            resp_timeout <= 1'b0;
        end else if (tx_done) begin
            to_run <= 1'b1;
            to_cnt <= '0;
        end else if (to_run) begin
            to_cnt <= to_cnt + 32'd1;
            if (to_cnt == TO_LAST) begin
                to_run       <= 1'b0;
                resp_timeout <= 1'b1;
            end
        end
    end
`else
    assign resp_timeout = 1'b0;
`endif

endmodule
